// File: rtl/reuleaux_pkg.sv
// Shared types and constants for the Reuleaux triangle drawer.
package reuleaux_pkg;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  // Signed coordinate width; wide enough for off-screen vertices and arc points.
  localparam int CW = 12;

  // sqrt(3)/6 and sqrt(3)/3 in Q0.16.
  localparam logic [15:0] SQRT3_6_Q16 = 16'd18919;
  localparam logic [15:0] SQRT3_3_Q16 = 16'd37837;

  typedef enum logic [2:0] {
    S0 = 3'b000,  // LOAD
    S1 = 3'b001,  // INIT
    S2 = 3'b010,  // CLEAR
    S3 = 3'b011,  // RIGHT
    S4 = 3'b100,  // LEFT
    S5 = 3'b101,  // TOP
    S6 = 3'b110   // DONE
  } pstate_e;

  typedef enum logic [1:0] {
    ARC_RIGHT = 2'd0,
    ARC_LEFT  = 2'd1,
    ARC_TOP   = 2'd2
  } arc_mode_e;

  // round(d * k / 65536) for an 8-bit d and Q0.16 constant k.
  function automatic logic [7:0] scale_round(input logic [7:0] d, input logic [15:0] k);
    logic [23:0] p;
    p = 24'(d) * 24'(k) + 24'd32768;
    return 8'(p >> 16);
  endfunction

endpackage

// File: rtl/reuleaux_draw_arc.sv
// Midpoint circle engine producing one octant candidate per cycle,
// filtered to one arc of the Reuleaux triangle and clipped to the screen.
module circle_arc
  import reuleaux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 init_i,
  input  logic signed [CW-1:0] ctr_x_i,
  input  logic signed [CW-1:0] ctr_y_i,
  input  logic        [7:0]    radius_i,
  input  arc_mode_e            mode_i,
  input  logic signed [CW-1:0] ref_x_i,
  input  logic signed [CW-1:0] ref_y_i,
  output logic        [7:0]    pix_x_o,
  output logic        [6:0]    pix_y_o,
  output logic                 plot_o,
  output logic                 done_o
);

  localparam logic signed [CW-1:0] ZERO = '0;
  localparam logic signed [CW-1:0] ONE  = CW'(1);
  localparam logic signed [CW-1:0] XLIM = CW'(SCR_W);
  localparam logic signed [CW-1:0] YLIM = CW'(SCR_H);

  logic signed [CW-1:0] ox_q, ox_d, oy_q, oy_d, crit_q, crit_d;
  logic        [2:0]    oct_q, oct_d;
  logic                 done_q, done_d;

  logic signed [CW-1:0] dx, dy, px, py, r_ext;
  logic                 keep, onscr;

  // Candidate pixel for the current octant, then arc filter and clip.
  always_comb begin
    case (oct_q)
      3'd0:    begin dx =  ox_q; dy =  oy_q; end
      3'd1:    begin dx =  oy_q; dy =  ox_q; end
      3'd2:    begin dx = -ox_q; dy =  oy_q; end
      3'd3:    begin dx = -oy_q; dy =  ox_q; end
      3'd4:    begin dx = -ox_q; dy = -oy_q; end
      3'd5:    begin dx = -oy_q; dy = -ox_q; end
      3'd6:    begin dx =  ox_q; dy = -oy_q; end
      default: begin dx =  oy_q; dy = -ox_q; end
    endcase
    px = ctr_x_i + dx;
    py = ctr_y_i + dy;
    case (mode_i)
      ARC_RIGHT: keep = (px >= ref_x_i) && (py <= ref_y_i);
      ARC_LEFT:  keep = (px <= ref_x_i) && (py <= ref_y_i);
      default:   keep = (py >= ref_y_i);
    endcase
    onscr = (px >= ZERO) && (px < XLIM) && (py >= ZERO) && (py < YLIM);
  end

  assign r_ext = $signed({{(CW-8){1'b0}}, radius_i});

  // Octant sequencing and midpoint error update after the eighth point.
  always_comb begin
    ox_d   = ox_q;
    oy_d   = oy_q;
    crit_d = crit_q;
    oct_d  = oct_q;
    done_d = done_q;
    if (init_i) begin
      ox_d   = r_ext;
      oy_d   = ZERO;
      crit_d = ONE - r_ext;
      oct_d  = 3'd0;
      done_d = 1'b0;
    end else if (en_i && !done_q) begin
      if (oct_q == 3'd7) begin
        oct_d = 3'd0;
        oy_d  = oy_q + ONE;
        if (crit_q <= ZERO) begin
          crit_d = crit_q + (oy_d <<< 1) + ONE;
        end else begin
          ox_d   = ox_q - ONE;
          crit_d = crit_q + ((oy_d - ox_d) <<< 1) + ONE;
        end
        if (oy_d > ox_d) done_d = 1'b1;
      end else begin
        oct_d = oct_q + 3'd1;
      end
    end
  end

  // Circle walker state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_q   <= '0;
      oy_q   <= '0;
      crit_q <= '0;
      oct_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      crit_q <= crit_d;
      oct_q  <= oct_d;
      done_q <= done_d;
    end
  end

  assign pix_x_o = px[7:0];
  assign pix_y_o = py[6:0];
  assign plot_o  = en_i && !done_q && keep && onscr;
  assign done_o  = done_q;

endmodule

// File: rtl/reuleaux_draw_fillscreen.sv
// Screen clear engine: walks every pixel once, column by column.
module fillscreen
  import reuleaux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic       plot_o,
  output logic       done
);

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       done_q, done_d;

  // Advance the raster position; disabling the engine rewinds it.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    done_d = done_q;
    if (!en_i) begin
      x_d    = '0;
      y_d    = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      if (y_q == 7'(SCR_H - 1)) begin
        y_d = '0;
        if (x_q == 8'(SCR_W - 1)) begin
          x_d    = '0;
          done_d = 1'b1;
        end else begin
          x_d = x_q + 8'd1;
        end
      end else begin
        y_d = y_q + 7'd1;
      end
    end
  end

  // Raster position and completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      done_q <= done_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign plot_o = en_i && !done_q;
  assign done   = done_q;

endmodule

// File: rtl/reuleaux_draw.sv
// Reuleaux triangle drawer: clears the screen, then draws the right,
// left and top arcs through the VGA pixel-plot interface.
module reuleaux_draw
  import reuleaux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  pstate_e pstate;

  logic [2:0] colour_q;
  logic [7:0] cx_q, d_q;
  logic [6:0] cy_q;
  logic signed [CW-1:0] cxs_q, rx_q, lx_q, base_q, ty_q;
  logic signed [CW-1:0] cx_w, cy_w, half_w, h6_w, h3_w;

  logic       finished_clear, finished_right, finished_left, finished_top;
  logic [7:0] fill_x;
  logic [6:0] fill_y;
  logic       fill_plot;

  logic                 arc_en, arc_init, arc_done, arc_plot;
  logic signed [CW-1:0] arc_cx, arc_cy;
  arc_mode_e            arc_mode;
  logic [7:0]           arc_x;
  logic [6:0]           arc_y;

  assign cx_w   = $signed({{(CW-8){1'b0}}, cx_q});
  assign cy_w   = $signed({{(CW-7){1'b0}}, cy_q});
  assign half_w = $signed({{(CW-7){1'b0}}, d_q[7:1]});
  assign h6_w   = $signed({{(CW-8){1'b0}}, scale_round(d_q, SQRT3_6_Q16)});
  assign h3_w   = $signed({{(CW-8){1'b0}}, scale_round(d_q, SQRT3_3_Q16)});

  // Capture drawing parameters on start, then derive the vertices once.
  always_ff @(posedge clk) begin
    if (pstate == S0 && start) begin
      colour_q <= colour;
      cx_q     <= centre_x;
      cy_q     <= centre_y;
      d_q      <= diameter;
    end
    if (pstate == S1) begin
      cxs_q  <= cx_w;
      rx_q   <= cx_w + half_w;
      lx_q   <= cx_w - half_w;
      base_q <= cy_w + h6_w;
      ty_q   <= cy_w - h3_w;
    end
  end

  fillscreen clear (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (pstate == S2),
    .x_o    (fill_x),
    .y_o    (fill_y),
    .plot_o (fill_plot),
    .done   (finished_clear)
  );

  // Each arc is centred on the opposite vertex; the engine reloads on every
  // state change so one instance serves all three arcs.
  always_comb begin
    arc_cx   = lx_q;
    arc_cy   = base_q;
    arc_mode = ARC_RIGHT;
    case (pstate)
      S4: begin
        arc_cx   = rx_q;
        arc_mode = ARC_LEFT;
      end
      S5: begin
        arc_cx   = cxs_q;
        arc_cy   = ty_q;
        arc_mode = ARC_TOP;
      end
      default: ;
    endcase
  end

  assign arc_en   = (pstate == S3) || (pstate == S4) || (pstate == S5);
  assign arc_init = !arc_en || arc_done;

  circle_arc arc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (arc_en),
    .init_i   (arc_init),
    .ctr_x_i  (arc_cx),
    .ctr_y_i  (arc_cy),
    .radius_i (d_q),
    .mode_i   (arc_mode),
    .ref_x_i  (cxs_q),
    .ref_y_i  (base_q),
    .pix_x_o  (arc_x),
    .pix_y_o  (arc_y),
    .plot_o   (arc_plot),
    .done_o   (arc_done)
  );

  assign finished_right = (pstate == S3) && arc_done;
  assign finished_left  = (pstate == S4) && arc_done;
  assign finished_top   = (pstate == S5) && arc_done;
  assign done           = (pstate == S6);

  // Sequencer with registered VGA outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate     <= S0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      case (pstate)
        S0: if (start) pstate <= S1;
        S1: pstate <= S2;
        S2: begin
          vga_x      <= fill_x;
          vga_y      <= fill_y;
          vga_colour <= 3'b000;
          vga_plot   <= fill_plot;
          if (finished_clear) pstate <= S3;
        end
        S3, S4, S5: begin
          vga_x      <= arc_x;
          vga_y      <= arc_y;
          vga_colour <= colour_q;
          vga_plot   <= arc_plot;
          if (finished_right) pstate <= S4;
          if (finished_left)  pstate <= S5;
          if (finished_top)   pstate <= S6;
        end
        S6: if (!start) pstate <= S0;
        default: pstate <= S0;
      endcase
    end
  end

endmodule

// File: tb/tb_reuleaux_draw.sv
// Bench for reuleaux_draw: reset walk, full draws against a geometric model.
module tb_reuleaux_draw;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] colour = '0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] diameter = '0;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  reuleaux_draw dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .colour     (colour),
    .centre_x   (centre_x),
    .centre_y   (centre_y),
    .diameter   (diameter),
    .start      (start),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int arc; int x; int y; int col; } pix_t;
  pix_t arc_q[$];
  int clr_cnt[256][128];
  int clr_total, clr_badcol, stray, offscreen, done_bad, s2_cycles, trans_seen, trans_bad;
  int prev_st = 0;
  int fin_from = 0;
  int exp_m[int];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    arc_q.delete();
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 128; y++) clr_cnt[x][y] = 0;
    clr_total = 0; clr_badcol = 0; stray = 0; offscreen = 0; done_bad = 0;
    s2_cycles = 0; trans_seen = 0; trans_bad = 0;
  endtask

  // Observe the pixel bus; vga_* carry the candidate from the previous cycle's state.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_st  = 0;
      fin_from = 0;
    end else begin
      if (vga_plot) begin
        if (vga_x >= 160 || vga_y >= 120) offscreen++;
        case (prev_st)
          2: begin
            clr_cnt[vga_x][vga_y]++;
            clr_total++;
            if (vga_colour != 3'b000) clr_badcol++;
          end
          3, 4, 5: arc_q.push_back('{prev_st, int'(vga_x), int'(vga_y), int'(vga_colour)});
          default: stray++;
        endcase
      end
      if (done !== (int'(dut.pstate) == 6)) done_bad++;
      if (fin_from != 0) begin
        trans_seen++;
        if (int'(dut.pstate) != fin_from + 1) trans_bad++;
      end
      fin_from = 0;
      case (int'(dut.pstate))
        2: if (dut.finished_clear) fin_from = 2;
        3: if (dut.finished_right) fin_from = 3;
        4: if (dut.finished_left)  fin_from = 4;
        5: if (dut.finished_top)   fin_from = 5;
        default: ;
      endcase
      if (int'(dut.pstate) == 2) s2_cycles++;
      prev_st = int'(dut.pstate);
    end
  end

  function automatic bit keep(input int a, input int px, input int py, input int cx, input int base);
    if (a == 3) return (px >= cx) && (py <= base);
    if (a == 4) return (px <= cx) && (py <= base);
    return py >= base;
  endfunction

  function automatic int arc_cx(input int a, input int cx, input int d);
    if (a == 3) return cx - d / 2;
    if (a == 4) return cx + d / 2;
    return cx;
  endfunction

  function automatic int arc_cy(input int a, input int cy, input int d);
    int h6, h3;
    h6 = (d * 18919 + 32768) / 65536;
    h3 = (d * 37837 + 32768) / 65536;
    return (a == 5) ? cy - h3 : cy + h6;
  endfunction

  // Every on-screen, in-filter point of the midpoint circle for each arc, with multiplicity.
  task automatic build_model(input int cx, input int cy, input int d);
    int base, ccx, ccy, ox, oy, crit, px, py, k;
    int dxs[8], dys[8];
    exp_m.delete();
    base = cy + (d * 18919 + 32768) / 65536;
    for (int a = 3; a <= 5; a++) begin
      ccx = arc_cx(a, cx, d);
      ccy = arc_cy(a, cy, d);
      ox = d; oy = 0; crit = 1 - d;
      while (oy <= ox) begin
        dxs = '{ox, oy, -ox, -oy, -ox, -oy, ox, oy};
        dys = '{oy, ox, oy, ox, -oy, -ox, -oy, -ox};
        for (int j = 0; j < 8; j++) begin
          px = ccx + dxs[j];
          py = ccy + dys[j];
          if (keep(a, px, py, cx, base) && px >= 0 && px < 160 && py >= 0 && py < 120) begin
            k = a * 100000 + px * 1000 + py;
            exp_m[k] = exp_m.exists(k) ? exp_m[k] + 1 : 1;
          end
        end
        oy++;
        if (crit <= 0) crit += 2 * oy + 1;
        else begin
          ox--;
          crit += 2 * (oy - ox) + 1;
        end
      end
    end
  endtask

  task automatic compare_arcs(input string tag, input int cx, input int cy, input int d,
                              input int col, input int max_arc);
    int got_m[int];
    int diff, geom, got_total, exp_total, a, dx, dy, r2, lo, hi, k, base;
    diff = 0; geom = 0; got_total = 0; exp_total = 0;
    build_model(cx, cy, d);
    base = cy + (d * 18919 + 32768) / 65536;
    lo = (d > 0) ? (d - 1) * (d - 1) : 0;
    hi = (d + 1) * (d + 1);
    foreach (arc_q[i]) begin
      a  = arc_q[i].arc;
      dx = arc_q[i].x - arc_cx(a, cx, d);
      dy = arc_q[i].y - arc_cy(a, cy, d);
      r2 = dx * dx + dy * dy;
      if (r2 < lo || r2 > hi || !keep(a, arc_q[i].x, arc_q[i].y, cx, base) ||
          arc_q[i].x >= 160 || arc_q[i].y >= 120 || arc_q[i].col != col) geom++;
      if (a <= max_arc) begin
        k = a * 100000 + arc_q[i].x * 1000 + arc_q[i].y;
        got_m[k] = got_m.exists(k) ? got_m[k] + 1 : 1;
        got_total++;
      end
    end
    foreach (exp_m[kk]) begin
      if (kk / 100000 <= max_arc) begin
        exp_total += exp_m[kk];
        if (!got_m.exists(kk) || got_m[kk] != exp_m[kk]) diff++;
      end
    end
    foreach (got_m[kk]) if (!exp_m.exists(kk)) diff++;
    check({tag, "_arc_pixel_set_diff"}, diff, 0);
    check({tag, "_arc_geometry_bad"}, geom, 0);
    check({tag, "_arc_pixel_count"}, got_total, exp_total);
  endtask

  task automatic check_clear(input string tag);
    int bad;
    bad = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) if (clr_cnt[x][y] != 1) bad++;
    check({tag, "_clear_not_once"}, bad, 0);
    check({tag, "_clear_total"}, clr_total, 19200);
    check({tag, "_clear_colour_bad"}, clr_badcol, 0);
  endtask

  task automatic wait_state(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(dut.pstate) == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic launch(input int c, input int cx, input int cy, input int d);
    clear_logs();
    colour   = 3'(c);
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    diameter = 8'(d);
    start    = 1'b1;
  endtask

  initial begin
    bit ok;
    int rcx, rcy, rd, rc;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_pstate", int'(dut.pstate), 0);
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_x", int'(vga_x), 0);
    check("rst_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    rst_n = 1'b1;

    // Reset walk.
    colour = 3'b010; centre_x = 8'd30; centre_y = 7'd120 - 7'd0; diameter = 8'd70; start = 1'b1;
    @(negedge clk);
    check("walk_s1", int'(dut.pstate), 1);
    #2 rst_n = 1'b0; #1;
    check("walk_rst_from_s1", int'(dut.pstate), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("walk_s2_after_2clk", int'(dut.pstate), 2);
    #2 rst_n = 1'b0; #1;
    check("walk_rst_from_s2", int'(dut.pstate), 0);
    check("walk_rst_plot", int'(vga_plot), 0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Full draw with handshake.
    launch(2, 30, 20, 80);
    wait_state(6, 30000, ok);
    check("A_reach_done_state", int'(ok), 1);
    check("A_done_high", int'(done), 1);
    repeat (3) @(negedge clk);
    check("A_hold_state", int'(dut.pstate), 6);
    check("A_hold_done", int'(done), 1);
    start = 1'b0;
    @(negedge clk);
    check("A_drop_state", int'(dut.pstate), 0);
    check("A_drop_done", int'(done), 0);
    check_clear("A");
    check("A_clear_cycles_ok", int'(s2_cycles >= 19200 && s2_cycles <= 19210), 1);
    check("A_transitions_seen", trans_seen, 4);
    check("A_transitions_bad", trans_bad, 0);
    check("A_stray_plots", stray, 0);
    check("A_done_decode_bad", done_bad, 0);
    compare_arcs("A", 30, 20, 80, 2, 5);

    // Clipping run, then reset out of the done state with start held.
    @(negedge clk);
    launch(2, 30, 120, 70);
    wait_state(6, 30000, ok);
    check("B_reach_done_state", int'(ok), 1);
    check("B_done_high", int'(done), 1);
    check("B_offscreen_plots", offscreen, 0);
    check("B_stray_plots", stray, 0);
    compare_arcs("B", 30, 120, 70, 2, 5);
    #2 rst_n = 1'b0; #1;
    check("B_rst_s6_pstate", int'(dut.pstate), 0);
    check("B_rst_s6_plot", int'(vga_plot), 0);
    check("B_rst_s6_done", int'(done), 0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Random parameters, reset while the top arc is in progress.
    rcx = int'($urandom_range(140, 20));
    rcy = int'($urandom_range(100, 30));
    rd  = int'($urandom_range(90, 10));
    rc  = int'($urandom_range(7, 0));
    launch(rc, rcx, rcy, rd);
    wait_state(5, 30000, ok);
    check("C_reach_top_state", int'(ok), 1);
    repeat (int'($urandom_range(30, 1))) @(negedge clk);
    check("C_still_top", int'(dut.pstate), 5);
    #2 rst_n = 1'b0; #1;
    check("C_rst_s5_pstate", int'(dut.pstate), 0);
    check("C_rst_s5_plot", int'(vga_plot), 0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_clear("C");
    check("C_transitions_seen", trans_seen, 3);
    check("C_transitions_bad", trans_bad, 0);
    compare_arcs("C", rcx, rcy, rd, rc, 4);
    @(negedge clk);

    // Zero diameter still completes.
    rcx = int'($urandom_range(159, 0));
    rcy = int'($urandom_range(119, 0));
    rc  = int'($urandom_range(7, 0));
    launch(rc, rcx, rcy, 0);
    wait_state(6, 30000, ok);
    check("D_reach_done_state", int'(ok), 1);
    check("D_transitions_bad", trans_bad, 0);
    compare_arcs("D", rcx, rcy, 0, rc, 5);
    start = 1'b0;
    @(negedge clk);
    check("D_drop_state", int'(dut.pstate), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
